// File: rtl/demux_ctrl_pkg.sv
// ============================================================================
// Module      : demux_ctrl_pkg
// Description : Shared constants and types for the 1x4 demux dispatcher.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package demux_ctrl_pkg;

    localparam int NCH = 4;

    localparam logic MODE_RR   = 1'b0;
    localparam logic MODE_ADDR = 1'b1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/demux_1x4_dispatcher_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker over a 4-bit request mask.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
    import demux_ctrl_pkg::*;
(
    input  logic [NCH-1:0] mask,
    input  logic [1:0]     last,
    output logic [1:0]     grant,
    output logic           grant_valid
);

    logic [1:0] w_idx;

    // Scan from farthest to nearest so the nearest enabled channel after
    // 'last' is the one that sticks.
    always_comb begin
        grant       = 2'd0;
        grant_valid = 1'b0;
        w_idx       = 2'd0;
        for (int i = NCH; i >= 1; i--) begin
            w_idx = last + 2'(i);
            if (mask[w_idx]) begin
                grant       = w_idx;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/demux_1x4_dispatcher.sv
// ============================================================================
// Module      : demux_1x4_dispatcher
// Description : One-word buffer routing a valid/ready stream to four channels
//               by round-robin or addressed selection, with saturating counts.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_1x4_dispatcher
    import demux_ctrl_pkg::*;
#(
    parameter int DW    = 8,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DW-1:0]        in_data,
    input  logic [1:0]           in_dest,
    input  logic                 mode,
    input  logic [NCH-1:0]       ch_en,
    output logic [DW-1:0]        out_data,
    output logic [NCH-1:0]       out_valid,
    input  logic [NCH-1:0]       out_ready,
    output logic [1:0]           sel,
    output logic                 busy,
    output logic [NCH*CNT_W-1:0] dlv_cnt,
    output logic [CNT_W-1:0]     drop_cnt
);

    state_t                        r_state_q, w_state_d;
    logic [DW-1:0]                 r_data_q, w_data_d;
    logic [1:0]                    r_sel_q, w_sel_d;
    logic [1:0]                    r_last_rr_q, w_last_rr_d;
    logic [NCH-1:0][CNT_W-1:0]     r_dlv_cnt_q, w_dlv_cnt_d;
    logic [CNT_W-1:0]              r_drop_cnt_q, w_drop_cnt_d;

    logic       w_rr_grant_valid;
    logic [1:0] w_rr_grant;
    logic       w_can_accept;
    logic       w_deliver;
    logic       w_fire;
    logic       w_drop;
    logic       w_load;
    logic [1:0] w_chan;
    logic [NCH-1:0] w_out_valid;

    rr_pick u_rr_pick (
        .mask        (ch_en),
        .last        (r_last_rr_q),
        .grant       (w_rr_grant),
        .grant_valid (w_rr_grant_valid)
    );

    // Addressed mode always accepts: a word for a disabled channel is
    // consumed and counted as a drop rather than stalling the producer.
    always_comb begin
        w_can_accept = (mode == MODE_ADDR) ? 1'b1 : w_rr_grant_valid;
        w_deliver    = (r_state_q == SEND) && out_ready[r_sel_q];
        in_ready     = ((r_state_q == IDLE) || w_deliver) && w_can_accept;
        w_fire       = in_valid && in_ready;
        w_drop       = w_fire && (mode == MODE_ADDR) && !ch_en[in_dest];
        w_load       = w_fire && !w_drop;
        w_chan       = (mode == MODE_ADDR) ? in_dest : w_rr_grant;
    end

    always_comb begin
        w_state_d    = r_state_q;
        w_data_d     = r_data_q;
        w_sel_d      = r_sel_q;
        w_last_rr_d  = r_last_rr_q;
        w_dlv_cnt_d  = r_dlv_cnt_q;
        w_drop_cnt_d = r_drop_cnt_q;

        if (w_deliver) begin
            w_state_d = IDLE;
            if (r_dlv_cnt_q[r_sel_q] != '1) begin
                w_dlv_cnt_d[r_sel_q] = r_dlv_cnt_q[r_sel_q] + CNT_W'(1);
            end
        end

        if (w_load) begin
            w_state_d = SEND;
            w_data_d  = in_data;
            w_sel_d   = w_chan;
            if (mode == MODE_RR) begin
                w_last_rr_d = w_rr_grant;
            end
        end

        if (w_drop && (r_drop_cnt_q != '1)) begin
            w_drop_cnt_d = r_drop_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q    <= IDLE;
            r_data_q     <= '0;
            r_sel_q      <= 2'd0;
            r_last_rr_q  <= 2'd3;
            r_dlv_cnt_q  <= '0;
            r_drop_cnt_q <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_data_q     <= w_data_d;
            r_sel_q      <= w_sel_d;
            r_last_rr_q  <= w_last_rr_d;
            r_dlv_cnt_q  <= w_dlv_cnt_d;
            r_drop_cnt_q <= w_drop_cnt_d;
        end
    end

    always_comb begin
        w_out_valid = '0;
        if (r_state_q == SEND) begin
            w_out_valid[r_sel_q] = 1'b1;
        end
    end

    assign out_valid = w_out_valid;
    assign out_data  = r_data_q;
    assign sel       = r_sel_q;
    assign busy      = (r_state_q == SEND);
    assign dlv_cnt   = r_dlv_cnt_q;
    assign drop_cnt  = r_drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_demux_1x4_dispatcher.sv
// ============================================================================
// Module      : tb_demux_1x4_dispatcher
// Description : Directed self-checking bench for demux_1x4_dispatcher.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux_1x4_dispatcher;

    localparam int DW    = 8;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_data;
    logic [1:0]       in_dest;
    logic             mode;
    logic [3:0]       ch_en;
    logic [DW-1:0]    out_data;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [1:0]       sel;
    logic             busy;
    logic [4*CNT_W-1:0] dlv_cnt;
    logic [CNT_W-1:0] drop_cnt;

    int checks;
    int errors;

    demux_1x4_dispatcher #(.DW(DW), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .mode      (mode),
        .ch_en     (ch_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel       (sel),
        .busy      (busy),
        .dlv_cnt   (dlv_cnt),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_dest = 2'd0;
        mode = 1'b0; ch_en = 4'hF; out_ready = 4'hF;
        step(); step();
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 4'h0) begin errors++; $display("FAIL reset_out_valid: got %h expected %h", out_valid, 4'h0); end
        checks++; if (sel !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d expected 0", sel); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
        checks++; if (dlv_cnt !== 32'h0) begin errors++; $display("FAIL reset_dlv_cnt: got %h expected 0", dlv_cnt); end
        checks++; if (drop_cnt !== 8'h0) begin errors++; $display("FAIL reset_drop_cnt: got %h expected 0", drop_cnt); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_rr_all();
        logic [1:0] exp_sel [5];
        exp_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        mode = 1'b0; ch_en = 4'hF; out_ready = 4'hF;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hA0 + 8'(i);
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rr_all_in_ready[%0d]: got %b expected 1", i, in_ready); end
            step();
            checks++; if (sel !== exp_sel[i] || out_data !== (8'hA0 + 8'(i)) || out_valid !== (4'b0001 << exp_sel[i])) begin
                errors++; $display("FAIL rr_all_word[%0d]: got sel=%0d data=%h valid=%b expected sel=%0d data=%h", i, sel, out_data, out_valid, exp_sel[i], 8'hA0 + 8'(i));
            end
        end
        in_valid = 1'b0;
        step();
        checks++; if (busy !== 1'b0 || out_valid !== 4'h0) begin errors++; $display("FAIL rr_all_idle: got busy=%b valid=%b expected 0/0", busy, out_valid); end
        checks++; if (dlv_cnt !== {8'd1, 8'd1, 8'd1, 8'd2}) begin errors++; $display("FAIL rr_all_dlv_cnt: got %h expected %h", dlv_cnt, {8'd1, 8'd1, 8'd1, 8'd2}); end
    endtask

    // last_rr is 0 after the previous test, so the 1010 mask yields 1, 3, 1.
    task automatic test_rr_masked();
        logic [1:0] exp_sel [3];
        exp_sel = '{2'd1, 2'd3, 2'd1};
        mode = 1'b0; ch_en = 4'b1010; out_ready = 4'hF;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hB0 + 8'(i);
            step();
            checks++; if (sel !== exp_sel[i] || out_valid !== (4'b0001 << exp_sel[i])) begin
                errors++; $display("FAIL rr_masked_sel[%0d]: got sel=%0d valid=%b expected sel=%0d", i, sel, out_valid, exp_sel[i]);
            end
        end
        in_valid = 1'b0;
        step();
        checks++; if (dlv_cnt !== {8'd2, 8'd1, 8'd3, 8'd2}) begin errors++; $display("FAIL rr_masked_dlv_cnt: got %h expected %h", dlv_cnt, {8'd2, 8'd1, 8'd3, 8'd2}); end
    endtask

    task automatic test_addr_drop();
        mode = 1'b1; ch_en = 4'b0111; in_dest = 2'd3; in_data = 8'h55; in_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL drop_in_ready: got %b expected 1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL drop_cnt: got %0d expected 1", drop_cnt); end
        checks++; if (out_valid !== 4'h0 || busy !== 1'b0) begin errors++; $display("FAIL drop_no_send: got valid=%b busy=%b expected 0/0", out_valid, busy); end
        step();
        checks++; if (out_valid !== 4'h0 || dlv_cnt !== {8'd2, 8'd1, 8'd3, 8'd2}) begin errors++; $display("FAIL drop_after: got valid=%b dlv=%h expected 0 and unchanged", out_valid, dlv_cnt); end
    endtask

    task automatic test_backpressure();
        mode = 1'b1; ch_en = 4'hF; in_dest = 2'd2; in_data = 8'h77; in_valid = 1'b1;
        out_ready = 4'b1011;
        step();
        in_valid = 1'b1; in_data = 8'h88; in_dest = 2'd0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (out_valid !== 4'b0100 || sel !== 2'd2 || out_data !== 8'h77 || in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold[%0d]: got valid=%b sel=%0d data=%h rdy=%b expected 0100/2/77/0", i, out_valid, sel, out_data, in_ready);
            end
            step();
        end
        in_valid = 1'b0; out_ready = 4'hF;
        step();
        checks++; if (busy !== 1'b0 || dlv_cnt[2*CNT_W +: CNT_W] !== 8'd2) begin
            errors++; $display("FAIL bp_release: got busy=%b dlv2=%0d expected 0/2", busy, dlv_cnt[2*CNT_W +: CNT_W]);
        end
    endtask

    // Back-to-back words to the same channel: each departure counts once.
    task automatic test_back_to_back();
        mode = 1'b1; ch_en = 4'hF; in_dest = 2'd1; out_ready = 4'hF;
        in_valid = 1'b1; in_data = 8'hC1;
        step();
        in_data = 8'hC2;
        step();
        in_valid = 1'b0;
        checks++; if (out_data !== 8'hC2 || sel !== 2'd1 || busy !== 1'b1 || dlv_cnt[1*CNT_W +: CNT_W] !== 8'd4) begin
            errors++; $display("FAIL b2b_mid: got data=%h sel=%0d busy=%b dlv1=%0d expected C2/1/1/4", out_data, sel, busy, dlv_cnt[1*CNT_W +: CNT_W]);
        end
        step();
        checks++; if (busy !== 1'b0 || dlv_cnt[1*CNT_W +: CNT_W] !== 8'd5) begin
            errors++; $display("FAIL b2b_end: got busy=%b dlv1=%0d expected 0/5", busy, dlv_cnt[1*CNT_W +: CNT_W]);
        end
    endtask

    // drop_cnt is 1 here; 300 more drops must stop at 255.
    task automatic test_drop_saturate();
        mode = 1'b1; ch_en = 4'b0111; in_dest = 2'd3; in_valid = 1'b1;
        for (int i = 0; i < 300; i++) step();
        in_valid = 1'b0;
        checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL drop_saturate: got %0d expected 255", drop_cnt); end
    endtask

    task automatic test_reset_mid_send();
        mode = 1'b1; ch_en = 4'hF; in_dest = 2'd0; in_data = 8'h99;
        out_ready = 4'h0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1 || out_valid !== 4'b0001) begin errors++; $display("FAIL mid_send_busy: got busy=%b valid=%b expected 1/0001", busy, out_valid); end
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 4'h0 || busy !== 1'b0 || dlv_cnt !== 32'h0 || drop_cnt !== 8'h0) begin
            errors++; $display("FAIL mid_send_reset: got valid=%b busy=%b dlv=%h drop=%h expected all 0", out_valid, busy, dlv_cnt, drop_cnt);
        end
        step();
        rst = 1'b0;
        out_ready = 4'hF; mode = 1'b0; ch_en = 4'h0; in_valid = 1'b1; in_data = 8'h11;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL empty_mask_ready: got %b expected 0", in_ready); end
        step();
        checks++; if (busy !== 1'b0 || out_valid !== 4'h0) begin errors++; $display("FAIL empty_mask_idle: got busy=%b valid=%b expected 0/0", busy, out_valid); end
        in_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_rr_all();
        test_rr_masked();
        test_addr_drop();
        test_backpressure();
        test_back_to_back();
        test_drop_saturate();
        test_reset_mid_send();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
